// File: rtl/lc3b_types.sv
// ============================================================================
//  Module      : lc3b_types (package)
//  Description : Shared LC-3b types for the memory hierarchy: word and cache
//                line widths, the cache arbiter FSM state encoding and the
//                default line-offset width.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    // A 128-bit line spans 16 bytes, so 4 address bits select within a line
    localparam int c_OFFSET_BITS = 4;

endpackage

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
//  Module      : cache_arbiter
//  Description : Arbitrates instruction-cache fills and data-cache fills /
//                writebacks onto a single physical-memory port. One pmem
//                transaction at a time; the granted side gets a one-cycle
//                resp pulse with the returned line.
//                Optional feature: define ARB_RR_EN for round-robin
//                arbitration on simultaneous requests (default: the data
//                side always wins).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_arbiter
    import lc3b_types::*;
#(
    parameter int OFFSET_BITS = c_OFFSET_BITS
) (
    input  logic         clk,
    input  logic         reset,

    // Instruction cache side
    input  logic         i_read,
    input  logic [15:0]  i_addr,
    output logic [127:0] i_rdata,
    output logic         i_resp,

    // Data cache side
    input  logic         d_read,
    input  logic         d_write,
    input  logic [15:0]  d_addr,
    input  logic [127:0] d_wdata,
    output logic [127:0] d_rdata,
    output logic         d_resp,

    // Physical memory side
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    // Clears the within-line offset bits of the latched address
    localparam lc3b_word c_ADDR_MASK = ~((16'd1 << OFFSET_BITS) - 16'd1);

    arb_state_e r_state;
    arb_state_e w_next_state;

    logic       r_sel_d;     // granted side: 1 = data cache, 0 = instruction cache
    logic       r_write;     // latched operation is a writeback
    lc3b_word   r_addr;
    lc3b_line   r_wdata;
    lc3b_line   r_line;      // last line returned by physical memory

    logic       w_d_req;
    logic       w_req_any;
    logic       w_grant_d;
    logic       w_prio_d;
    logic       w_busy;
    logic       w_accept;

    assign w_d_req   = d_read | d_write;
    assign w_req_any = i_read | w_d_req;
    assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign w_accept  = (r_state == IDLE) && w_req_any;

`ifdef ARB_RR_EN
    // Priority pointer: 1 means the data side wins the next tie
    logic r_prio_d;

    // After every grant, priority passes to the side that was not served
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio_d <= 1'b1;
        end else if (w_accept) begin
            r_prio_d <= ~w_grant_d;
        end
    end

    assign w_prio_d = r_prio_d;
`else
    assign w_prio_d = 1'b1;
`endif

    // Data side is granted when it is the only requester or it holds priority
    assign w_grant_d = w_d_req && (!i_read || w_prio_d);

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_any) begin
                    w_next_state = w_grant_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (pmem_resp) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the granted request at acceptance; requester inputs are not
    // looked at again until the FSM is back in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_d <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_sel_d <= w_grant_d;
            r_write <= w_grant_d & d_write;   // read+write together is a write
            r_addr  <= w_grant_d ? d_addr  : i_addr;
            r_wdata <= w_grant_d ? d_wdata : '0;
        end
    end

    // Capture the returned line; it stays visible until the next completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_line <= '0;
        end else if (w_busy && pmem_resp) begin
            r_line <= pmem_rdata;
        end
    end

    assign pmem_read    = w_busy & ~r_write;
    assign pmem_write   = w_busy &  r_write;
    assign pmem_address = r_addr & c_ADDR_MASK;
    assign pmem_wdata   = r_wdata;

    assign i_resp  = (r_state == RESP) & ~r_sel_d;
    assign d_resp  = (r_state == RESP) &  r_sel_d;
    assign i_rdata = r_line;
    assign d_rdata = r_line;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
//  Module      : tb_cache_arbiter
//  Description : Self-checking bench for cache_arbiter. Acts as both L1
//                requesters and as physical memory; expected grants follow
//                the arbitration rule (data priority, or alternation when
//                ARB_RR_EN is defined).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_arbiter;

    localparam int OFF = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_read;
    logic [15:0]  i_addr;
    logic [127:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_addr;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: pending requests and arbitration priority
    logic         m_prio_d;
    logic         m_i_pend;
    logic [15:0]  m_i_addr;
    logic         m_d_pend;
    logic         m_d_wr;
    logic [15:0]  m_d_addr;
    logic [127:0] m_d_wdata;

    always #5 clk = ~clk;

    cache_arbiter #(.OFFSET_BITS(OFF)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Arbitration rule applied to the model's pending set
    function automatic logic model_grant_d();
        return m_d_pend && (!m_i_pend || m_prio_d);
    endfunction

    function automatic void model_after_grant(input logic gd);
`ifdef ARB_RR_EN
        m_prio_d = ~gd;
`else
        m_prio_d = 1'b1 | gd;
`endif
        if (gd) m_d_pend = 1'b0;
        else    m_i_pend = 1'b0;
    endfunction

    // Plays memory for one transaction: waits for the strobe, checks the
    // request on every busy cycle, answers after lat cycles, checks resp.
    task automatic do_txn(input string tag, input logic exp_d, input logic exp_wr,
                          input logic [15:0] exp_addr, input logic [127:0] exp_wdata,
                          input int lat, input logic [127:0] mem_data);
        logic        seen;
        logic [15:0] exp_pa;
        exp_pa = exp_addr & (16'hFFFF << OFF);
        seen   = 1'b0;
        for (int t = 0; t < 8 && !seen; t++) begin
            @(negedge clk);
            if (pmem_read || pmem_write) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            $display("FAIL %s start: no pmem strobe within 8 cycles", tag);
            n_err++;
            return;
        end
        for (int k = 0; k < lat; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++;
            if ({pmem_write, pmem_read} !== (exp_wr ? 2'b10 : 2'b01)) begin
                $display("FAIL %s op: got w=%b r=%b want write=%b", tag, pmem_write, pmem_read, exp_wr);
                n_err++;
            end
            n_checks++;
            if (pmem_address !== exp_pa) begin
                $display("FAIL %s addr: got %h want %h", tag, pmem_address, exp_pa);
                n_err++;
            end
            if (exp_wr) begin
                n_checks++;
                if (pmem_wdata !== exp_wdata) begin
                    $display("FAIL %s wdata: got %h want %h", tag, pmem_wdata, exp_wdata);
                    n_err++;
                end
            end
            n_checks++;
            if ({i_resp, d_resp} !== 2'b00) begin
                $display("FAIL %s busy_resp: got i=%b d=%b want 0 0", tag, i_resp, d_resp);
                n_err++;
            end
            if (k == lat - 1) begin
                pmem_resp  = 1'b1;
                pmem_rdata = mem_data;
            end
        end
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
        n_checks++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            $display("FAIL %s strobes_in_resp: got r=%b w=%b want 0 0", tag, pmem_read, pmem_write);
            n_err++;
        end
        n_checks++;
        if ({i_resp, d_resp} !== {~exp_d, exp_d}) begin
            $display("FAIL %s resp: got i=%b d=%b want i=%b d=%b", tag, i_resp, d_resp, ~exp_d, exp_d);
            n_err++;
        end
        n_checks++;
        if ((exp_d ? d_rdata : i_rdata) !== mem_data) begin
            $display("FAIL %s rdata: got %h want %h", tag, exp_d ? d_rdata : i_rdata, mem_data);
            n_err++;
        end
        // Requester sees its resp and drops the request
        if (exp_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_prio_d = 1'b1;
        m_i_pend = 1'b0;
        m_d_pend = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
            $display("FAIL reset_strobes: got r=%b w=%b ir=%b dr=%b want 0000",
                     pmem_read, pmem_write, i_resp, d_resp);
            n_err++;
        end
        n_checks++;
        if ({i_rdata, d_rdata, pmem_wdata, pmem_address} !== '0) begin
            $display("FAIL reset_data: got i_rdata=%h d_rdata=%h addr=%h want 0", i_rdata, d_rdata, pmem_address);
            n_err++;
        end
    endtask

    task automatic test_i_read();
        logic [127:0] line;
        line   = {16{8'hA5}};
        i_read = 1'b1;
        i_addr = 16'h1234;
        do_txn("i_read", 1'b0, 1'b0, 16'h1234, '0, 3, line);
        @(negedge clk);
        n_checks++;
        if ({i_resp, d_resp} !== 2'b00) begin
            $display("FAIL i_read_single_pulse: got i=%b d=%b want 0 0", i_resp, d_resp);
            n_err++;
        end
        n_checks++;
        if (i_rdata !== line) begin
            $display("FAIL i_read_hold: got %h want %h", i_rdata, line);
            n_err++;
        end
        model_after_grant(1'b0);
    endtask

    task automatic test_priority();
        logic [127:0] ld;
        logic [127:0] li;
        logic [15:0]  ia;
        ld = rand_line();
        li = rand_line();
        ia = 16'(($urandom));
        i_read  = 1'b1;
        i_addr  = ia;
        d_write = 1'b1;
        d_addr  = 16'h4000;
        d_wdata = {16{8'h55}};
        m_i_pend = 1'b1;
        m_d_pend = 1'b1;
        n_checks++;
        if (model_grant_d() !== 1'b1) begin
            $display("FAIL prio_model: priority pointer not on data side after reset");
            n_err++;
        end
        do_txn("prio_d", 1'b1, 1'b1, 16'h4000, {16{8'h55}}, 2, ld);
        model_after_grant(1'b1);
        do_txn("prio_i", 1'b0, 1'b0, ia, '0, 2, li);
        model_after_grant(1'b0);
    endtask

    task automatic test_rw_both();
        logic [15:0]  a;
        logic [127:0] w;
        a = 16'(($urandom));
        w = rand_line();
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = a;
        d_wdata = w;
        m_d_pend = 1'b1;
        do_txn("rw_both", 1'b1, 1'b1, a, w, 4, rand_line());
        model_after_grant(1'b1);
    endtask

    // Both sides keep re-requesting immediately after each resp
    task automatic test_back_to_back();
        logic [15:0]  da;
        logic [15:0]  ia;
        logic [127:0] dw;
        logic         gd;
        da = 16'(($urandom));
        ia = 16'(($urandom));
        dw = rand_line();
        i_read = 1'b1;  i_addr = ia;
        d_read = 1'b1;  d_write = 1'b0; d_addr = da; d_wdata = dw;
        m_i_pend = 1'b1;
        m_d_pend = 1'b1;
        for (int n = 0; n < 4; n++) begin
            gd = model_grant_d();
            do_txn(gd ? "b2b_d" : "b2b_i", gd, 1'b0, gd ? da : ia, '0,
                   int'($urandom_range(1, 3)), rand_line());
            model_after_grant(gd);
            if (n < 3) begin
                if (gd) begin d_read = 1'b1; da = 16'(($urandom)); d_addr = da; m_d_pend = 1'b1; end
                else    begin i_read = 1'b1; ia = 16'(($urandom)); i_addr = ia; m_i_pend = 1'b1; end
            end
        end
        // Drain whichever request is still outstanding
        if (m_i_pend || m_d_pend) begin
            gd = model_grant_d();
            do_txn("b2b_drain", gd, 1'b0, gd ? da : ia, '0, 1, rand_line());
            model_after_grant(gd);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        d_read = 1'b1;
        d_addr = 16'(($urandom));
        seen = 1'b0;
        for (int t = 0; t < 8 && !seen; t++) begin
            @(negedge clk);
            if (pmem_read) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            $display("FAIL rst_mid_start: no pmem_read within 8 cycles");
            n_err++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            $display("FAIL rst_mid_strobes: got r=%b w=%b want 0 0", pmem_read, pmem_write);
            n_err++;
        end
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        d_read     = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            pmem_resp = 1'b0;
            n_checks++;
            if ({d_resp, i_resp, pmem_read, pmem_write} !== 4'b0000) begin
                $display("FAIL rst_mid_idle: got dr=%b ir=%b r=%b w=%b want 0000",
                         d_resp, i_resp, pmem_read, pmem_write);
                n_err++;
            end
        end
        m_prio_d = 1'b1;
        m_i_pend = 1'b0;
        m_d_pend = 1'b0;
        // FSM must be back in IDLE and accept a fresh request normally
        i_read = 1'b1;
        i_addr = 16'(($urandom));
        m_i_addr = i_addr;
        do_txn("rst_mid_after", 1'b0, 1'b0, m_i_addr, '0, 2, rand_line());
        model_after_grant(1'b0);
    endtask

    task automatic test_random();
        logic gd;
        int   r;
        for (int n = 0; n < 24; n++) begin
            if (!m_i_pend && $urandom_range(0, 1) == 1) begin
                m_i_pend = 1'b1;
                m_i_addr = 16'(($urandom));
                i_read   = 1'b1;
                i_addr   = m_i_addr;
            end
            if (!m_d_pend && ($urandom_range(0, 1) == 1 || !m_i_pend)) begin
                r = int'($urandom_range(0, 2));
                m_d_pend  = 1'b1;
                m_d_wr    = (r != 0);
                m_d_addr  = 16'(($urandom));
                m_d_wdata = rand_line();
                d_read    = (r != 1);
                d_write   = (r != 0);
                d_addr    = m_d_addr;
                d_wdata   = m_d_wdata;
            end
            gd = model_grant_d();
            do_txn(gd ? "rand_d" : "rand_i", gd, gd & m_d_wr,
                   gd ? m_d_addr : m_i_addr, m_d_wdata,
                   int'($urandom_range(1, 4)), rand_line());
            model_after_grant(gd);
        end
        if (m_i_pend || m_d_pend) begin
            gd = model_grant_d();
            do_txn("rand_drain", gd, gd & m_d_wr, gd ? m_d_addr : m_i_addr,
                   m_d_wdata, 1, rand_line());
            model_after_grant(gd);
        end
    endtask

    initial begin
        reset      = 1'b1;
        i_read     = 1'b0;
        i_addr     = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        m_d_wr     = 1'b0;
        m_d_addr   = '0;
        m_d_wdata  = '0;
        m_i_addr   = '0;

        test_reset();
        test_i_read();
        test_reset();
        test_priority();
        test_rw_both();
        test_back_to_back();
        test_reset_mid();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter OFFSET_BITS, default 4, the number of line-offset address bits forced to zero on pmem_address.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_read  in  1  instruction-cache line fill request.
REQ-005 SHALL have port i_addr  in  16  instruction-cache line address (lc3b_word).
REQ-006 SHALL have port i_rdata  out  128  fill data returned to the instruction cache (lc3b_line).
REQ-007 SHALL have port i_resp  out  1  instruction-side completion pulse.
REQ-008 SHALL have port d_read  in  1  data-cache line fill request.
REQ-009 SHALL have port d_write  in  1  data-cache line writeback request.
REQ-010 SHALL have port d_addr  in  16  data-cache line address.
REQ-011 SHALL have port d_wdata  in  128  writeback line.
REQ-012 SHALL have port d_rdata  out  128  fill data returned to the data cache.
REQ-013 SHALL have port d_resp  out  1  data-side completion pulse.
REQ-014 SHALL have ports pmem_read  out  1,  pmem_write  out  1,  pmem_address  out  16,  pmem_wdata  out  128: physical-memory request.
REQ-015 SHALL have ports pmem_rdata  in  128,  pmem_resp  in  1: physical-memory response.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP.
REQ-017 In IDLE with a pending request, SHALL grant one side, latch its address, op and wdata, and enter BUSY_I/BUSY_D on the next edge.
REQ-018 With both sides pending in IDLE, SHALL grant the data side (fixed priority) unless ARB_RR_EN is defined.
REQ-019 If d_read and d_write are both high, SHALL treat the request as a write.
REQ-020 In BUSY_x, SHALL drive pmem_read or pmem_write (exactly one) from latched state, pmem_address = latched address with its low OFFSET_BITS zeroed, and pmem_wdata = latched wdata; requester inputs are ignored while busy.
REQ-021 On pmem_resp in BUSY_x, SHALL capture pmem_rdata into a line register and enter RESP; pmem strobes deassert from that edge.
REQ-022 In RESP, SHALL assert x_resp for exactly one cycle with x_rdata = captured line, then return to IDLE.
REQ-023 Minimum request-to-resp latency SHALL be pmem latency + 2 cycles; at most one pmem transaction outstanding.
REQ-024 Requesters SHALL hold requests until x_resp; a request still high in IDLE after RESP is a new request.
REQ-025 i_rdata/d_rdata SHALL hold the last captured line between responses; the non-granted resp stays 0.

Reset
REQ-026 Reset SHALL force IDLE, all strobes and resp outputs 0, latched address/data and rdata registers 0, priority pointer to the data side.
REQ-027 Reset mid-transaction SHALL abandon it: strobes low on the next edge, no resp issued, late pmem_resp ignored in IDLE.

Configuration
REQ-028 Macro ARB_RR_EN defined: on simultaneous requests, SHALL grant the side not served last (round-robin pointer updated at each grant); undefined: fixed data priority, no pointer register.

Structure
REQ-029 lc3b_line (128-bit) and the FSM state enum SHALL live in lc3b_types; OFFSET_BITS default is a package constant.
REQ-030 Single module; no sub-module; mp3 instantiates it between the two L1 caches and physical memory.

Verification
REQ-031 i_read=1, i_addr=0x1234, pmem_resp after 3 cycles with 0xA5.. -> pmem_address=0x1230, i_rdata=0xA5.., i_resp one cycle, d_resp=0.
REQ-032 i_read and d_write (d_addr=0x4000, wdata=0x55..) same cycle, fixed priority -> pmem_write first at 0x4000, then pmem_read for I; two resps in order D, I.
REQ-033 ARB_RR_EN, both sides requesting continuously for four transactions -> grants alternate D, I, D, I.
REQ-034 d_read=d_write=1 -> pmem_write=1, pmem_read=0 throughout.
REQ-035 Reset asserted in BUSY_D, pmem_resp arrives one cycle after -> strobes low, no d_resp, FSM IDLE.
